// File: rtl/bit_transition_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit_transition_scheduler_if
// Brief    : Request/grant, event handshake and counter read bundle.
// Revision : 1.0
// ============================================================================
interface bit_transition_scheduler_if #(
    parameter int NCH = 4,
    parameter int CW  = 8,
    parameter int IDW = 2
);
    logic [NCH-1:0] Req;
    logic [NCH-1:0] X;
    logic [NCH-1:0] Gnt;
    logic           EvValid;
    logic           EvReady;
    logic [IDW-1:0] EvCh;
    logic           EvDir;
    logic           CntClr;
    logic [IDW-1:0] RdSel;
    logic [CW-1:0]  RdCnt;

    modport master (
        output Req, X, EvReady, CntClr, RdSel,
        input  Gnt, EvValid, EvCh, EvDir, RdCnt
    );

    modport slave (
        input  Req, X, EvReady, CntClr, RdSel,
        output Gnt, EvValid, EvCh, EvDir, RdCnt
    );
endinterface
`default_nettype wire

// File: rtl/bit_transition_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit_transition_scheduler
// Brief    : Round-robin shared bit-transition detector with event register
//            and saturating per-channel transition counters.
// Revision : 1.0
// ============================================================================
module bit_transition_scheduler #(
    parameter int NCH = 4,
    parameter int CW  = 8,
    parameter int IDW = 2
) (
    input  logic                        Clk,
    input  logic                        Clr,
    bit_transition_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        HIST_NONE = 2'd0,
        HIST_0    = 2'd1,
        HIST_1    = 2'd2
    } hist_t;

    localparam logic [CW-1:0] C_CNT_MAX = '1;

    hist_t          r_hist     [NCH];
    hist_t          w_hist_nxt [NCH];
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_nxt;
    logic           w_stall;
    logic           w_found;
    logic [IDW-1:0] w_idx;
    logic           w_grant;
    logic           w_bit;
    logic           w_trans;
    logic [NCH-1:0] w_gnt;
    logic           r_ev_valid;
    logic [IDW-1:0] r_ev_ch;
    logic           r_ev_dir;
    logic [CW-1:0]  r_cnt [NCH];
    logic [CW-1:0]  w_rd_cnt;

    assign w_stall = r_ev_valid && !bus.EvReady;

    // Cyclic search for the first requester at or after the pointer.
    always_comb begin : p_arb
        int             w_j;
        logic [IDW-1:0] w_sel;
        w_j     = 0;
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NCH) begin
                w_j = w_j - NCH;
            end
            w_sel = w_j[IDW-1:0];
            if (!w_found && bus.Req[w_sel]) begin
                w_found = 1'b1;
                w_idx   = w_sel;
            end
        end
    end

    // Clr gates the grant so nothing is offered while reset is asserted.
    assign w_grant = w_found && !w_stall && Clr;
    assign w_bit   = bus.X[w_idx];
    assign w_trans = w_grant &&
                     (((r_hist[w_idx] == HIST_0) &&  w_bit) ||
                      ((r_hist[w_idx] == HIST_1) && !w_bit));

    always_comb begin : p_gnt
        w_gnt = '0;
        if (w_grant) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign bus.Gnt = w_gnt;

    always_comb begin : p_hist_nxt
        for (int k = 0; k < NCH; k++) begin
            w_hist_nxt[k] = r_hist[k];
        end
        if (w_grant) begin
            w_hist_nxt[w_idx] = w_bit ? HIST_1 : HIST_0;
        end
    end

    always_comb begin : p_ptr_nxt
        w_ptr_nxt = r_ptr;
        if (w_grant) begin
            w_ptr_nxt = (int'(w_idx) == NCH - 1) ? '0 : w_idx + IDW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin : p_state
        if (!Clr) begin
            for (int k = 0; k < NCH; k++) begin
                r_hist[k] <= HIST_NONE;
            end
            r_ptr <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                r_hist[k] <= w_hist_nxt[k];
            end
            r_ptr <= w_ptr_nxt;
        end
    end

    // A new event takes priority over consumption so throughput is one per cycle.
    always_ff @(posedge Clk or negedge Clr) begin : p_event
        if (!Clr) begin
            r_ev_valid <= 1'b0;
            r_ev_ch    <= '0;
            r_ev_dir   <= 1'b0;
        end else if (w_trans) begin
            r_ev_valid <= 1'b1;
            r_ev_ch    <= w_idx;
            r_ev_dir   <= w_bit;
        end else if (bus.EvReady) begin
            r_ev_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin : p_count
        if (!Clr) begin
            for (int k = 0; k < NCH; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (bus.CntClr) begin
            for (int k = 0; k < NCH; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (w_trans && (r_cnt[w_idx] != C_CNT_MAX)) begin
            r_cnt[w_idx] <= r_cnt[w_idx] + CW'(1);
        end
    end

    // Select values with no matching channel read back as zero.
    always_comb begin : p_rd
        w_rd_cnt = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.RdSel == IDW'(k)) begin
                w_rd_cnt = r_cnt[k];
            end
        end
    end

    assign bus.RdCnt   = w_rd_cnt;
    assign bus.EvValid = r_ev_valid;
    assign bus.EvCh    = r_ev_ch;
    assign bus.EvDir   = r_ev_dir;

endmodule
`default_nettype wire

// File: tb/tb_bit_transition_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for bit_transition_scheduler: directed scenarios with literal
// expectations followed by random traffic against a behavioural model.
module tb_bit_transition_scheduler;

    localparam int NCH = 3;
    localparam int CW  = 2;
    localparam int IDW = 2;

    logic Clk;
    logic Clr;

    bit_transition_scheduler_if #(.NCH(NCH), .CW(CW), .IDW(IDW)) bus ();

    bit_transition_scheduler #(.NCH(NCH), .CW(CW), .IDW(IDW)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors;
    int checks;

    // Behavioural model: last bit per channel (-1 = none), pointer, event, counts.
    int m_last [NCH];
    int m_cnt  [NCH];
    int m_ptr;
    int m_ev_v;
    int m_ev_ch;
    int m_ev_dir;

    // Values observed at the most recent step.
    int s_gnt, s_ev_v, s_ev_ch, s_ev_dir, s_rd;
    int g_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_last[k] = -1;
            m_cnt[k]  = 0;
        end
        m_ptr    = 0;
        m_ev_v   = 0;
        m_ev_ch  = 0;
        m_ev_dir = 0;
    endtask

    function automatic int model_grant(input logic [NCH-1:0] req, input logic rdy);
        int r;
        r = int'(req);
        if (m_ev_v != 0 && !rdy) return -1;
        for (int i = 0; i < NCH; i++) begin
            int k;
            k = (m_ptr + i) % NCH;
            if (((r >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    task automatic model_update(input int k, input logic [NCH-1:0] x, input logic rdy, input logic cclr);
        int xv;
        int b;
        bit trans;
        xv    = int'(x);
        b     = 0;
        trans = 1'b0;
        if (k >= 0) begin
            b       = (xv >> k) & 1;
            trans   = (m_last[k] >= 0) && (m_last[k] != b);
            m_last[k] = b;
            m_ptr   = (k + 1) % NCH;
        end
        if (trans) begin
            m_ev_v   = 1;
            m_ev_ch  = k;
            m_ev_dir = b;
        end else if (m_ev_v != 0 && rdy) begin
            m_ev_v = 0;
        end
        if (cclr) begin
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        end else if (trans && m_cnt[k] < (1 << CW) - 1) begin
            m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    // Called at posedge+1; drives inputs, compares at negedge, advances model at posedge.
    task automatic step(input logic [NCH-1:0] req, input logic [NCH-1:0] x,
                        input logic rdy, input logic cclr, input logic [IDW-1:0] rs);
        int k;
        int exp_gnt;
        int exp_rd;
        bus.Req     = req;
        bus.X       = x;
        bus.EvReady = rdy;
        bus.CntClr  = cclr;
        bus.RdSel   = rs;
        @(negedge Clk);
        k       = model_grant(req, rdy);
        exp_gnt = (k >= 0) ? (1 << k) : 0;
        exp_rd  = (int'(rs) < NCH) ? m_cnt[int'(rs)] : 0;
        s_gnt    = int'(bus.Gnt);
        s_ev_v   = int'(bus.EvValid);
        s_ev_ch  = int'(bus.EvCh);
        s_ev_dir = int'(bus.EvDir);
        s_rd     = int'(bus.RdCnt);
        chk("gnt",      bus.Gnt,     exp_gnt);
        chk("ev_valid", bus.EvValid, m_ev_v);
        chk("ev_ch",    bus.EvCh,    m_ev_ch);
        chk("ev_dir",   bus.EvDir,   m_ev_dir);
        chk("rd_cnt",   bus.RdCnt,   exp_rd);
        @(posedge Clk);
        model_update(k, x, rdy, cclr);
        g_last = k;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [4:0] d1_x;
        bit [4:0] d1_ev;
        bit [4:0] sat_x;
        logic [NCH-1:0] xv;
        int hreq;
        int hx;

        errors = 0;
        checks = 0;
        g_last = -1;
        d1_x   = 5'b01100;
        d1_ev  = 5'b01000;
        sat_x  = 5'b01010;

        // Reset state, with requests present to show Gnt is held off.
        Clr         = 1'b0;
        bus.Req     = '1;
        bus.X       = '0;
        bus.EvReady = 1'b1;
        bus.CntClr  = 1'b0;
        bus.RdSel   = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_gnt",      bus.Gnt,     0);
        chk("rst_ev_valid", bus.EvValid, 0);
        chk("rst_ev_ch",    bus.EvCh,    0);
        chk("rst_ev_dir",   bus.EvDir,   0);
        chk("rst_cnt",      bus.RdCnt,   0);
        bus.Req = '0;
        @(negedge Clk);
        Clr = 1'b1;
        @(posedge Clk);
        #1;

        // Single channel 0 with bits 0,0,1,1,0.
        for (int i = 0; i < 5; i++) begin
            xv    = '0;
            xv[0] = d1_x[i];
            step(3'b001, xv, 1'b1, 1'b0, 2'd0);
            chk("d1_gnt",      s_gnt,  3'b001);
            chk("d1_ev_valid", s_ev_v, d1_ev[i]);
            if (i == 3) begin
                chk("d1_rise_ch",  s_ev_ch,  0);
                chk("d1_rise_dir", s_ev_dir, 1);
            end
        end
        step(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        chk("d1_fall_valid", s_ev_v,   1);
        chk("d1_fall_dir",   s_ev_dir, 0);
        chk("d1_cnt",        s_rd,     2);

        // Round robin with all requesting; pointer starts at 1 here.
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 3'b000, 1'b1, 1'b0, 2'd0);
            chk("rr_gnt", s_gnt, 1 << ((1 + i) % 3));
        end

        // Backpressure: event on channel 1 held while channel 2 waits.
        step(3'b010, 3'b010, 1'b0, 1'b0, 2'd0);
        chk("bp_first_gnt", s_gnt, 3'b010);
        for (int i = 0; i < 3; i++) begin
            step(3'b100, 3'b100, 1'b0, 1'b0, 2'd0);
            chk("bp_stall_gnt",  s_gnt,    0);
            chk("bp_stall_vld",  s_ev_v,   1);
            chk("bp_stall_ch",   s_ev_ch,  1);
            chk("bp_stall_dir",  s_ev_dir, 1);
        end
        step(3'b100, 3'b100, 1'b1, 1'b0, 2'd0);
        chk("bp_release_gnt", s_gnt, 3'b100);
        step(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        chk("bp_reload_vld", s_ev_v,  1);
        chk("bp_reload_ch",  s_ev_ch, 2);

        // Saturation on channel 1, out-of-range read, clear beating increment.
        step(3'b000, 3'b000, 1'b1, 1'b1, 2'd1);
        for (int i = 0; i < 5; i++) begin
            xv    = '0;
            xv[1] = sat_x[i];
            step(3'b010, xv, 1'b1, 1'b0, 2'd1);
        end
        step(3'b000, 3'b000, 1'b1, 1'b0, 2'd1);
        chk("sat_cnt", s_rd, 3);
        step(3'b000, 3'b000, 1'b1, 1'b0, 2'd3);
        chk("rd_oor", s_rd, 0);
        step(3'b010, 3'b010, 1'b1, 1'b1, 2'd1);
        step(3'b000, 3'b000, 1'b1, 1'b0, 2'd1);
        chk("clr_cnt",   s_rd,     0);
        chk("clr_ev_vld", s_ev_v,  1);
        chk("clr_ev_ch", s_ev_ch,  1);
        chk("clr_ev_dir", s_ev_dir, 1);

        // Asynchronous reset while an event is pending and channel 0 is at 1.
        step(3'b001, 3'b001, 1'b1, 1'b0, 2'd0);
        chk("ar_pre_valid", bus.EvValid, 1);
        bus.Req     = 3'b111;
        bus.EvReady = 1'b0;
        #2;
        Clr = 1'b0;
        #1;
        chk("ar_ev_valid", bus.EvValid, 0);
        chk("ar_gnt",      bus.Gnt,     0);
        model_reset();
        bus.Req = '0;
        Clr     = 1'b1;
        @(posedge Clk);
        #1;
        step(3'b001, 3'b000, 1'b1, 1'b0, 2'd0);
        chk("ar_first_gnt", s_gnt, 3'b001);
        step(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
        chk("ar_no_event", s_ev_v, 0);

        // Random traffic; requests are held with stable bits until granted.
        hreq = 0;
        hx   = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NCH; k++) begin
                if (((hreq >> k) & 1) == 0 && $urandom_range(0, 1) == 1) begin
                    hreq = hreq | (1 << k);
                    if ($urandom_range(0, 1) == 1) hx = hx | (1 << k);
                    else                           hx = hx & ~(1 << k);
                end
            end
            step(NCH'(hreq), NCH'(hx), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, IDW'($urandom_range(0, 3)));
            if (g_last >= 0) hreq = hreq & ~(1 << g_last);
            if (c == 250 || c == 450) begin
                #2;
                Clr = 1'b0;
                #1;
                chk("rand_rst_valid", bus.EvValid, 0);
                chk("rand_rst_gnt",   bus.Gnt,     0);
                model_reset();
                bus.Req = '0;
                Clr     = 1'b1;
                @(posedge Clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_transition_scheduler.md
Name: bit_transition_scheduler

Overview:
Shares one Mealy-style bit-transition detector (flags when the current serial bit differs from the previous bit) among NCH serial channels. A round-robin arbiter grants one channel per cycle. The granted bit is compared against that channel's saved history. Detected transitions are queued to a one-entry event register with a valid/ready handshake, and a saturating per-channel transition count is kept. The block sits between the serial front-end samplers and the event/statistics consumer.

Parameters:
NCH, 4, number of requesting serial channels (2..16)
CW, 8, width of each per-channel transition counter
IDW, 2, channel index width; must equal ceil(log2(NCH))

Ports:
Clk  in  1  rising-edge clock
Clr  in  1  asynchronous, active-low reset
Req  in  NCH  per-channel sample request; held by requester until granted
X  in  NCH  per-channel sample bit; stable while the matching Req is high
Gnt  out  NCH  one-hot grant, combinational, same cycle as accepted sample
EvValid  out  1  event register holds an unconsumed transition
EvReady  in  1  consumer accepts event when EvValid && EvReady at rising edge
EvCh  out  IDW  channel index of the held event
EvDir  out  1  new bit value of the held event: 1 = 0->1, 0 = 1->0
CntClr  in  1  synchronous clear of all transition counters
RdSel  in  IDW  counter read select
RdCnt  out  CW  count[RdSel], combinational; 0 if RdSel >= NCH

Behaviour:
- Clock and reset: one clock, Clk. Clr is asynchronous and active-low.
- Reset (Clr=0), asynchronous:
  - every channel history = NONE
  - all counters = 0; round-robin pointer Ptr = 0
  - EvValid = 0, EvCh = 0, EvDir = 0
  - Gnt forced to 0
- Reset mid-operation discards any pending event and history. The first sample after reset never produces an event.
- Per-channel history FSM, 3 states: NONE, H0 (last bit 0), H1 (last bit 1).
  - On grant of channel k with bit b: history[k] <= (b ? H1 : H0) from any state.
  - Transition occurs iff (history[k]==H0 && b==1) or (history[k]==H1 && b==0).
  - NONE never produces a transition.
  - Ungranted channels keep their state.
- Stall = EvValid && !EvReady. When stall=1, Gnt = 0 and no channel state changes.
- Arbitration when not stalled:
  - Gnt = lowest-index requester at or after Ptr, searching cyclically.
  - At most one grant per cycle.
  - After a grant to k, Ptr <= (k+1) mod NCH. With no grant, Ptr holds.
- Event register:
  - A transition at the grant edge sets EvValid=1, EvCh=k, EvDir=b on the next cycle, i.e. one cycle after Gnt.
  - Consumption and a new transition on the same edge: the register reloads with the new event and EvValid stays 1. Throughput is 1 event/cycle.
  - Consumption with no new transition: EvValid <= 0. EvCh and EvDir hold their last values.
  - While EvValid && !EvReady, EvCh and EvDir are stable.
- Counters:
  - On a transition, count[k] <= count[k]+1, saturating at 2^CW-1 with no wrap.
  - CntClr=1 sets every counter to 0 on that edge and overrides a same-cycle increment, so the result is 0.
  - CntClr does not affect history, Ptr, or the event register.
- Unused Req bits with no grant have no effect. X is ignored for ungranted channels.

Test Plan:
- Reset then single channel: Req[0]=1 with X[0] sequence 0,0,1,1,0 over consecutive granted cycles, EvReady=1 -> events only after bits 3 and 5 (EvCh=0, EvDir=1 then 0), one cycle after the respective Gnt; count[0]=2.
- Round-robin: all Req=1111 held for 8 cycles, EvReady=1 -> Gnt sequence 0001,0010,0100,1000,0001,...; Ptr wraps 3->0.
- Backpressure: create an event with EvReady=0 for 3 cycles and Req[2]=1 pending -> Gnt=0 during the stall, EvCh/EvDir stable. EvReady=1 -> Gnt[2] in that same cycle; if channel 2 transitions, EvValid stays 1 with EvCh=2.
- Saturation and clear, with CW=2: 5 transitions on channel 1 -> RdSel=1 gives RdCnt=3. CntClr=1 in the same cycle as a transition -> RdCnt=0 afterwards; the event is still issued.
- Async reset mid-stream: pull Clr low between clocks while EvValid=1 and history H1 -> EvValid=0 immediately. After release, X=0 on the first grant gives no event.
- RdSel out of range, with NCH=3, IDW=2: RdSel=3 -> RdCnt=0.
